// File: rtl/exp_pkg.sv
// Shared constants and helpers for the e^x Taylor pipeline.
// Coefficients are stored in Q3.23 and rescaled to the datapath FRAC.
package exp_pkg;

  localparam int MAX_ORDER = 7;
  localparam int Q_FRAC    = 23;
  localparam int SAT_IW    = 128;

  localparam int INV_FACT_Q323 [0:7] = '{
    8388608, 8388608, 4194304, 1398101,
    349525, 69905, 11651, 1664
  };

  typedef logic signed [SAT_IW-1:0] wide_t;

  // k outside the table yields 0 (used by the E-scale stage).
  function automatic longint coef_q(
    input int k,
    input int frac
  );
    longint c;
    if (k < 0 || k > MAX_ORDER) return 0;
    c = longint'(INV_FACT_Q323[k[2:0]]);
    if (frac >= Q_FRAC) return c <<< (frac - Q_FRAC);
    return c >>> (Q_FRAC - frac);
  endfunction

  function automatic wide_t sat_w(
    input wide_t v,
    input int    w
  );
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/exp_taylor_pipe_if.sv
// Valid/ready stream bundle for the Taylor pipeline.
// master drives samples in and consumes results; slave is the pipeline.
interface exp_taylor_pipe_if #(
  parameter int W     = 26,
  parameter int TAG_W = 32
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     in_A;
  logic signed [W-1:0]     in_E;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W-1:0]     out_res;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_sat;

  modport master (
    output in_valid, in_A, in_E, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, out_sat
  );

  modport slave (
    input  in_valid, in_A, in_E, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, out_sat
  );

endinterface

// File: rtl/exp_horner_stage.sv
// One elastic multiply-add-saturate stage of the Horner chain.
// USE_E selects E as multiplicand for the final scaling stage.
module exp_horner_stage
  import exp_pkg::*;
#(
  parameter int     W     = 26,
  parameter int     FRAC  = 23,
  parameter int     TAG_W = 32,
  parameter longint COEF  = 0,
  parameter bit     USE_E = 1'b0
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                flush,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic signed [W-1:0] acc_i,
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] e_i,
  input  logic [TAG_W-1:0]    tag_i,
  input  logic                sat_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic signed [W-1:0] acc_o,
  output logic signed [W-1:0] a_o,
  output logic signed [W-1:0] e_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                sat_o
);

  localparam int PW = 2 * W;

  logic signed [PW-1:0] acc_x;
  logic signed [PW-1:0] mul_x;
  logic signed [PW-1:0] prod;
  wide_t                sum_w;
  wide_t                sat_v;
  logic                 clamp;

  logic                 valid_q, valid_d;
  logic signed [W-1:0]  acc_q, acc_d;
  logic signed [W-1:0]  a_q, a_d;
  logic signed [W-1:0]  e_q, e_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 sat_q, sat_d;

  assign ready_o = !valid_q | ready_i;

  always_comb begin
    acc_x   = PW'(acc_i);
    mul_x   = USE_E ? PW'(e_i) : PW'(a_i);
    prod    = acc_x * mul_x;
    sum_w   = wide_t'(prod >>> FRAC) + wide_t'(COEF);
    sat_v   = sat_w(sum_w, W);
    clamp   = (sat_v != sum_w);
    valid_d = valid_q;
    acc_d   = acc_q;
    a_d     = a_q;
    e_d     = e_q;
    tag_d   = tag_q;
    sat_d   = sat_q;
    if (ready_o) begin
      valid_d = valid_i;
      acc_d   = sat_v[W-1:0];
      a_d     = a_i;
      e_d     = e_i;
      tag_d   = tag_i;
      sat_d   = sat_i | clamp;
    end
    if (flush) valid_d = 1'b0;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      a_q     <= '0;
      e_q     <= '0;
      tag_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      e_q     <= e_d;
      tag_q   <= tag_d;
      sat_q   <= sat_d;
    end
  end

  assign valid_o = valid_q;
  assign acc_o   = acc_q;
  assign a_o     = a_q;
  assign e_o     = e_q;
  assign tag_o   = tag_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/exp_taylor_pipe.sv
// Elastic e^x datapath: ORDER Horner stages then one E-scale stage.
// Ready ripples back combinationally so bubbles collapse at full rate.
module exp_taylor_pipe
  import exp_pkg::*;
#(
  parameter int W     = 26,
  parameter int FRAC  = 23,
  parameter int ORDER = 3,
  parameter int TAG_W = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             flush,
  exp_taylor_pipe_if.slave io,
  output logic             busy
);

  localparam int NS = ORDER + 1;

  logic [NS:0]         vld;
  logic [NS+1:1]       rdy;
  logic [NS:0]         sat;
  logic signed [W-1:0] acc [0:NS];
  logic signed [W-1:0] a   [0:NS];
  logic signed [W-1:0] e   [0:NS];
  logic [TAG_W-1:0]    tag [0:NS];
  logic                unused_tail;

  assign vld[0]      = io.in_valid;
  assign acc[0]      = W'(coef_q(ORDER, FRAC));
  assign a[0]        = io.in_A;
  assign e[0]        = io.in_E;
  assign tag[0]      = io.in_tag;
  assign sat[0]      = 1'b0;
  assign rdy[NS+1]   = io.out_ready;
  assign io.in_ready = rdy[1] & !flush;

  for (genvar k = 1; k <= NS; k++) begin : g_stage
    exp_horner_stage #(
      .W     (W),
      .FRAC  (FRAC),
      .TAG_W (TAG_W),
      .COEF  (coef_q(ORDER - k, FRAC)),
      .USE_E (k == NS)
    ) u_stage (
      .CLK     (CLK),
      .rst     (rst),
      .flush   (flush),
      .valid_i (vld[k-1]),
      .ready_o (rdy[k]),
      .acc_i   (acc[k-1]),
      .a_i     (a[k-1]),
      .e_i     (e[k-1]),
      .tag_i   (tag[k-1]),
      .sat_i   (sat[k-1]),
      .valid_o (vld[k]),
      .ready_i (rdy[k+1]),
      .acc_o   (acc[k]),
      .a_o     (a[k]),
      .e_o     (e[k]),
      .tag_o   (tag[k]),
      .sat_o   (sat[k])
    );
  end

  assign io.out_valid = vld[NS];
  assign io.out_res   = acc[NS];
  assign io.out_tag   = tag[NS];
  assign io.out_sat   = sat[NS];
  assign busy         = |vld[NS:1];
  assign unused_tail  = ^{a[NS], e[NS]};

endmodule

// File: tb/tb_exp_taylor_pipe.sv
// Randomised + directed bench for exp_taylor_pipe.
// Reference: plain Horner evaluation with clamping, FIFO scoreboard.
module tb_exp_taylor_pipe;

  localparam int W     = 26;
  localparam int FRAC  = 23;
  localparam int ORDER = 3;
  localparam int TAG_W = 32;
  localparam int LAT   = ORDER + 1;

  localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) <<< (W - 1));
  localparam longint ONE  = longint'(1) <<< FRAC;

  localparam longint IFACT [0:7] = '{
    8388608, 8388608, 4194304, 1398101,
    349525, 69905, 11651, 1664
  };

  typedef struct {
    longint           res;
    logic [TAG_W-1:0] tag;
    bit               sat;
  } exp_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;

  int n_chk = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;
  exp_t q[$];

  exp_taylor_pipe_if #(.W(W), .TAG_W(TAG_W)) io ();

  exp_taylor_pipe #(
    .W     (W),
    .FRAC  (FRAC),
    .ORDER (ORDER),
    .TAG_W (TAG_W)
  ) dut (
    .CLK   (CLK),
    .rst   (rst),
    .flush (flush),
    .io    (io),
    .busy  (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void clip(inout longint v, inout bit s);
    if (v > SMAX) begin
      v = SMAX;
      s = 1'b1;
    end else if (v < SMIN) begin
      v = SMIN;
      s = 1'b1;
    end
  endfunction

  function automatic exp_t model(input longint a, input longint e,
                                 input logic [TAG_W-1:0] tag);
    exp_t   r;
    longint acc;
    r.sat = 1'b0;
    r.tag = tag;
    acc   = IFACT[ORDER];
    for (int k = 1; k <= ORDER; k++) begin
      acc = ((acc * a) >>> FRAC) + IFACT[ORDER-k];
      clip(acc, r.sat);
    end
    acc = (acc * e) >>> FRAC;
    clip(acc, r.sat);
    r.res = acc;
    return r;
  endfunction

  function automatic longint rnd_a();
    longint v;
    if ($urandom_range(0, 3) == 0) begin
      v = longint'($urandom_range(0, 32'h3FFFFFF));
      if (v > SMAX) v = v - 64'sd67108864;
    end else begin
      v = longint'($urandom_range(0, 32'h1FFFFFF)) - 64'sd16777216;
    end
    return v;
  endfunction

  function automatic longint rnd_e();
    return longint'($urandom_range(1, 32'h1FFFFFF));
  endfunction

  // Scoreboard: peek head every valid cycle, so stalls must hold data.
  always @(negedge CLK) begin
    if (rst) begin
      q.delete();
    end else begin
      if (io.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          check("res", longint'(io.out_res), q[0].res);
          check("tag", longint'(io.out_tag), longint'(q[0].tag));
          check("sat", longint'(io.out_sat), longint'(q[0].sat));
          if (io.out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (io.in_valid && io.in_ready) begin
        q.push_back(model(longint'(io.in_A), longint'(io.in_E),
                          io.in_tag));
        n_in++;
      end
      if (flush) q.delete();
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input longint a, input longint e,
                      input logic [TAG_W-1:0] tag);
    bit ok;
    io.in_valid = 1'b1;
    io.in_A     = a[W-1:0];
    io.in_E     = e[W-1:0];
    io.in_tag   = tag;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      ok = io.in_ready;
      tick();
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) send(rnd_a(), rnd_e(), $urandom);
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() > 0; i++) tick();
    check("drain", q.size(), 0);
  endtask

  task automatic directed(input string nm, input longint a,
                          input longint e, input logic [TAG_W-1:0] tag,
                          input longint exp_res, input bit exp_sat);
    int cyc;
    send(a, e, tag);
    io.in_valid = 1'b0;
    cyc = 1;
    while (!io.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({nm, "_lat"}, cyc, LAT);
    check({nm, "_res"}, longint'(io.out_res), exp_res);
    check({nm, "_tag"}, longint'(io.out_tag), longint'(tag));
    check({nm, "_sat"}, longint'(io.out_sat), longint'(exp_sat));
    tick();
  endtask

  initial begin
    int i0;
    int o0;
    bit done;
    io.in_valid  = 1'b0;
    io.in_A      = '0;
    io.in_E      = '0;
    io.in_tag    = '0;
    io.out_ready = 1'b1;
    #12;
    check("rst_valid", io.out_valid, 0);
    check("rst_res", longint'(io.out_res), 0);
    check("rst_tag", longint'(io.out_tag), 0);
    check("rst_sat", io.out_sat, 0);
    check("rst_busy", busy, 0);
    #2 rst = 1'b0;
    tick();

    directed("t1", 0, ONE, 32'h3F800000, ONE, 1'b0);
    directed("t2p", ONE, ONE, 32'h11111111, 22369621, 1'b0);
    directed("t2n", -ONE, ONE, 32'h22222222, 2796203, 1'b0);
    directed("t3", 33470000, 33470000, 32'h33333333, 33554431, 1'b1);
    check("t3_idle", busy, 0);

    // Stall: 1010 then 10 cycles held low.
    i0 = n_in;
    o0 = n_out;
    fork
      stream(16);
      begin
        for (int i = 0; i < 4; i++) begin
          io.out_ready = (i % 2 == 0);
          tick();
        end
        io.out_ready = 1'b0;
        repeat (10) tick();
        @(negedge CLK);
        check("t4_in_ready", io.in_ready, 0);
        check("t4_buffered", q.size(), LAT);
        @(posedge CLK);
        #1 io.out_ready = 1'b1;
      end
    join
    drain();
    check("t4_in_cnt", n_in - i0, 16);
    check("t4_out_cnt", n_out - o0, 16);

    // Full pipe, simultaneous in/out every cycle.
    io.out_ready = 1'b0;
    stream(LAT);
    io.out_ready = 1'b1;
    i0 = n_in;
    o0 = n_out;
    io.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      io.in_A   = rnd_a()[W-1:0];
      io.in_E   = rnd_e()[W-1:0];
      io.in_tag = $urandom;
      @(negedge CLK);
      check("t5_in_ready", io.in_ready, 1);
      check("t5_out_valid", io.out_valid, 1);
      tick();
    end
    io.in_valid = 1'b0;
    check("t5_in_cnt", n_in - i0, 20);
    check("t5_out_cnt", n_out - o0, 20);
    drain();

    // Random backpressure.
    done = 1'b0;
    fork
      begin
        stream(40);
        done = 1'b1;
      end
      begin
        while (!done) begin
          io.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        io.out_ready = 1'b1;
      end
    join
    drain();

    // Async reset with samples in flight.
    stream(3);
    #2 rst = 1'b1;
    #4;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_valid", io.out_valid, 0);
    #1 rst = 1'b0;
    tick();
    check("t6_rst_edge_busy", busy, 0);
    check("t6_rst_edge_valid", io.out_valid, 0);
    repeat (6) tick();
    check("t6_rst_quiet", io.out_valid, 0);
    directed("t6r", ONE, ONE, 32'h44444444, 22369621, 1'b0);

    // Flush with samples in flight.
    stream(3);
    flush = 1'b1;
    @(negedge CLK);
    check("t6_flush_in_ready", io.in_ready, 0);
    tick();
    flush = 1'b0;
    check("t6_flush_busy", busy, 0);
    check("t6_flush_valid", io.out_valid, 0);
    repeat (6) tick();
    check("t6_flush_quiet", io.out_valid, 0);
    directed("t6f", -ONE, ONE, 32'h55555555, 2796203, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
